// File: rtl/iter_shift_unit_if.sv
// Request/response handshake bundle for the iterative shifter.
interface iter_shift_unit_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = 5
);
  // Request side (from register file / immediate path)
  logic               valid_i;
  logic               ready_o;
  logic [XLEN-1:0]    data_i;
  logic [SHAMT_W-1:0] shamt_i;
  logic [2:0]         funct3_i;
  logic               arith_i;
  // Result side (to writeback)
  logic               valid_o;
  logic               ready_i;
  logic [XLEN-1:0]    data_o;
  // Stall indication to the control unit
  logic               busy_o;

  // The shifter itself
  modport slave (
    input  valid_i, data_i, shamt_i, funct3_i, arith_i, ready_i,
    output ready_o, valid_o, data_o, busy_o
  );

  // The producer/consumer around the shifter
  modport master (
    output valid_i, data_i, shamt_i, funct3_i, arith_i, ready_i,
    input  ready_o, valid_o, data_o, busy_o
  );
endinterface

// File: rtl/iter_shift_unit.sv
// Iterative one-bit-per-cycle shifter for SLL/SRL/SRA and their immediate forms.
module iter_shift_unit #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  iter_shift_unit_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRL = 3'b101;

  logic [1:0]         state_q, state_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]    work_q,  work_d;
  logic               left_q,  left_d;
  logic               arith_q, arith_d;
  logic               valid_q, valid_d;
  logic [XLEN-1:0]    data_q,  data_d;

  logic               is_left_c;
  logic               is_shift_c;
  logic [XLEN-1:0]    shifted_c;

  // Decode the requested operation class
  assign is_left_c  = (bus.funct3_i == F3_SLL);
  assign is_shift_c = (bus.funct3_i == F3_SLL) || (bus.funct3_i == F3_SRL);

  // One-position step of the work register; arith_q is only ever set for right shifts
  assign shifted_c = left_q ? {work_q[XLEN-2:0], 1'b0}
                            : {arith_q & work_q[XLEN-1], work_q[XLEN-1:1]};

  // Handshake and status outputs
  assign bus.ready_o = (state_q == S_IDLE) & ~rst_i;
  assign bus.busy_o  = (state_q != S_IDLE);
  assign bus.valid_o = valid_q;
  assign bus.data_o  = data_q;

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    work_d  = work_q;
    left_d  = left_q;
    arith_d = arith_q;
    valid_d = valid_q;
    data_d  = data_q;

    case (state_q)
      S_IDLE: begin
        if (bus.valid_i && bus.ready_o) begin
          work_d  = bus.data_i;
          count_d = bus.shamt_i;
          left_d  = is_left_c;
          arith_d = bus.arith_i & ~is_left_c;
          if ((bus.shamt_i == '0) || !is_shift_c) begin
            data_d  = bus.data_i;
            valid_d = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end

      S_SHIFT: begin
        work_d  = shifted_c;
        count_d = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) begin
          data_d  = shifted_c;
          valid_d = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (bus.ready_i) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset discards any in-flight operation
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      count_q <= '0;
      work_q  <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      work_q  <= work_d;
      left_q  <= left_d;
      arith_q <= arith_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_iter_shift_unit.sv
// Self-checking bench for iter_shift_unit: transaction-level model plus directed and random stimulus.
module tb_iter_shift_unit;

  logic clk_i = 1'b0;
  logic rst_i;

  iter_shift_unit_if #(.XLEN(32), .SHAMT_W(5)) bus();

  iter_shift_unit #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  // Architectural result of a shift instruction
  function automatic logic [31:0] ref_fn(input logic [31:0] d, input logic [4:0] s,
                                         input logic [2:0] f, input logic a);
    case (f)
      3'b001:  return d << s;
      3'b101:  return a ? 32'($signed(d) >>> s) : (d >> s);
      default: return d;
    endcase
  endfunction

  // Edges from accept to valid_o
  function automatic int lat_fn(input logic [4:0] s, input logic [2:0] f);
    if (s == 5'd0 || (f != 3'b001 && f != 3'b101)) return 1;
    return int'(s) + 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Transaction-level model: in flight, countdown to result, result holding
  logic        m_inflight = 1'b0, n_inflight;
  logic        m_valid = 1'b0,    n_valid;
  logic [31:0] m_data = '0,       n_data;
  logic [31:0] m_res = '0,        n_res;
  int          m_left = 0,        n_left;
  logic        m_acc = 1'b0,      n_acc;

  always_comb begin
    n_inflight = m_inflight;
    n_valid    = m_valid;
    n_data     = m_data;
    n_res      = m_res;
    n_left     = m_left;
    n_acc      = 1'b0;
    if (rst_i) begin
      n_inflight = 1'b0;
      n_valid    = 1'b0;
      n_data     = '0;
      n_res      = '0;
      n_left     = 0;
    end else if (m_valid) begin
      if (bus.ready_i) begin
        n_valid    = 1'b0;
        n_inflight = 1'b0;
      end
    end else begin
      if (!m_inflight && bus.valid_i) begin
        n_inflight = 1'b1;
        n_acc      = 1'b1;
        n_res      = ref_fn(bus.data_i, bus.shamt_i, bus.funct3_i, bus.arith_i);
        n_left     = lat_fn(bus.shamt_i, bus.funct3_i);
      end
      if (n_inflight) begin
        n_left = n_left - 1;
        if (n_left == 0) begin
          n_valid = 1'b1;
          n_data  = n_res;
        end
      end
    end
  end

  always @(posedge clk_i) begin
    m_inflight <= n_inflight;
    m_valid    <= n_valid;
    m_data     <= n_data;
    m_res      <= n_res;
    m_left     <= n_left;
    m_acc      <= n_acc;
  end

  // Cycle-by-cycle comparison against the model, mid-cycle
  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("cyc_valid_o", 32'(bus.valid_o), 32'(m_valid));
      chk("cyc_data_o",  bus.data_o, m_data);
      chk("cyc_busy_o",  32'(bus.busy_o), 32'(m_inflight));
      chk("cyc_ready_o", 32'(bus.ready_o), 32'(!m_inflight && !rst_i));
    end
  end

  // Present a request and return just after the edge that accepts it
  task automatic accept_op(input logic [31:0] d, input logic [4:0] s,
                           input logic [2:0] f, input logic a);
    int n;
    bus.data_i   = d;
    bus.shamt_i  = s;
    bus.funct3_i = f;
    bus.arith_i  = a;
    bus.valid_i  = 1'b1;
    n = 0;
    while (!bus.ready_o && n < 50) begin
      @(posedge clk_i); #2;
      n++;
    end
    if (!bus.ready_o) chk("accept_timeout", 32'(bus.ready_o), 32'd1);
    @(posedge clk_i); #2;
    bus.valid_i = 1'b0;
  endtask

  // Count edges from accept until valid_o (accept edge counts as 1)
  task automatic wait_valid(output int edges);
    edges = 1;
    while (!bus.valid_o && edges < 40) begin
      @(posedge clk_i); #2;
      edges++;
    end
    if (!bus.valid_o) chk("valid_timeout", 32'(bus.valid_o), 32'd1);
  endtask

  task automatic run_op(input string nm, input logic [31:0] d, input logic [4:0] s,
                        input logic [2:0] f, input logic a,
                        input logic [31:0] exp_d, input int exp_lat);
    int e;
    accept_op(d, s, f, a);
    wait_valid(e);
    chk({nm, "_data"}, bus.data_o, exp_d);
    chk({nm, "_lat"}, 32'(e), 32'(exp_lat));
    bus.ready_i = 1'b1;
    @(posedge clk_i); #2;
    bus.ready_i = 1'b0;
  endtask

  initial begin
    int e;
    int sel;
    rst_i        = 1'b1;
    bus.valid_i  = 1'b1;
    bus.data_i   = 32'hFFFF_FFFF;
    bus.shamt_i  = 5'd3;
    bus.funct3_i = 3'b001;
    bus.arith_i  = 1'b0;
    bus.ready_i  = 1'b0;

    // Pin the model against hand-computed values
    chk("model_sll31", ref_fn(32'h0000_0001, 5'd31, 3'b001, 1'b0), 32'h8000_0000);
    chk("model_sra4",  ref_fn(32'h8000_00F0, 5'd4, 3'b101, 1'b1), 32'hF800_000F);
    chk("model_srl4",  ref_fn(32'h8000_00F0, 5'd4, 3'b101, 1'b0), 32'h0800_000F);
    chk("model_lat31", 32'(lat_fn(5'd31, 3'b001)), 32'd32);

    // Reset held for two edges with a request pending
    @(posedge clk_i); #1;
    chk_en = 1'b1;
    @(posedge clk_i); #2;
    chk("rst_valid_o", 32'(bus.valid_o), 32'd0);
    chk("rst_data_o",  bus.data_o, 32'd0);
    chk("rst_busy_o",  32'(bus.busy_o), 32'd0);
    rst_i       = 1'b0;
    bus.valid_i = 1'b0;
    #1;
    chk("rst_ready_after", 32'(bus.ready_o), 32'd1);
    @(posedge clk_i); #2;

    run_op("sll31", 32'h0000_0001, 5'd31, 3'b001, 1'b0, 32'h8000_0000, 32);
    run_op("sra4",  32'h8000_00F0, 5'd4,  3'b101, 1'b1, 32'hF800_000F, 5);
    run_op("srl4",  32'h8000_00F0, 5'd4,  3'b101, 1'b0, 32'h0800_000F, 5);
    run_op("shamt0", 32'hDEAD_BEEF, 5'd0, 3'b001, 1'b0, 32'hDEAD_BEEF, 1);
    run_op("f3pass", 32'hDEAD_BEEF, 5'd7, 3'b000, 1'b1, 32'hDEAD_BEEF, 1);

    // Backpressure in DONE with a new request waiting
    accept_op(32'h1234_5678, 5'd2, 3'b001, 1'b0);
    wait_valid(e);
    chk("bp_lat", 32'(e), 32'd3);
    bus.data_i   = 32'h0000_000F;
    bus.shamt_i  = 5'd1;
    bus.funct3_i = 3'b101;
    bus.arith_i  = 1'b0;
    bus.valid_i  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid_o", 32'(bus.valid_o), 32'd1);
      chk("bp_data_o",  bus.data_o, 32'h48D1_59E0);
      chk("bp_ready_o", 32'(bus.ready_o), 32'd0);
      @(posedge clk_i); #2;
    end
    bus.ready_i = 1'b1;
    @(posedge clk_i); #2;
    bus.ready_i = 1'b0;
    chk("bp_idle_valid", 32'(bus.valid_o), 32'd0);
    chk("bp_idle_ready", 32'(bus.ready_o), 32'd1);
    chk("bp_idle_data",  bus.data_o, 32'h48D1_59E0);
    @(posedge clk_i); #2;
    bus.valid_i = 1'b0;
    chk("bp_next_busy", 32'(bus.busy_o), 32'd1);
    wait_valid(e);
    chk("bp_next_data", bus.data_o, 32'h0000_0007);
    chk("bp_next_lat",  32'(e), 32'd2);
    bus.ready_i = 1'b1;
    @(posedge clk_i); #2;
    bus.ready_i = 1'b0;

    // Reset on the fifth SHIFT edge aborts the operation
    accept_op(32'hABCD_0123, 5'd20, 3'b001, 1'b0);
    repeat (4) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    @(posedge clk_i); #2;
    rst_i = 1'b0;
    chk("abort_busy",  32'(bus.busy_o), 32'd0);
    chk("abort_valid", 32'(bus.valid_o), 32'd0);
    chk("abort_data",  bus.data_o, 32'd0);
    repeat (25) @(posedge clk_i);
    #2;
    chk("abort_no_valid", 32'(bus.valid_o), 32'd0);
    run_op("after_abort", 32'h0000_0001, 5'd3, 3'b001, 1'b0, 32'h0000_0008, 4);

    // Randomized traffic with random backpressure and occasional resets
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk_i); #2;
      rst_i       = ($urandom_range(0, 199) == 0);
      bus.ready_i = ($urandom_range(0, 2) != 0);
      if (!bus.valid_i || m_acc) begin
        if ($urandom_range(0, 9) < 7) begin
          bus.valid_i = 1'b1;
          bus.data_i  = $urandom;
          sel = int'($urandom_range(0, 3));
          bus.shamt_i = (sel == 0) ? 5'd0 : (sel == 1) ? 5'd31 : 5'($urandom_range(0, 31));
          sel = int'($urandom_range(0, 3));
          bus.funct3_i = (sel < 2) ? 3'b001 : (sel == 2) ? 3'b101 : 3'($urandom_range(0, 7));
          bus.arith_i = 1'($urandom_range(0, 1));
        end else begin
          bus.valid_i = 1'b0;
        end
      end
    end

    @(posedge clk_i); #2;
    rst_i       = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    repeat (40) @(posedge clk_i);
    #2;
    chk("drain_idle", 32'(bus.busy_o), 32'd0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
